uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and counter widths.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int UART_BIT_CNT_W            = 3;
    localparam int UART_BAUD_W               = 16;
    localparam int DATA_W                    = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restarts on clear or at every bit boundary.
// bit_tick marks the last clock of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    output logic [UART_BAUD_W-1:0] count,
    output logic                   bit_tick
);

    localparam logic [UART_BAUD_W-1:0] LAST = UART_BAUD_W'(CLKS_PER_BIT - 1);

    assign bit_tick = (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed by a show-ahead fifo: 8N1 framing, one complete pulse (fifo pop) per byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_tx_valid,
    input  logic [DATA_W-1:0] uart_tx_data,
    output logic              uart_tx_complete,
    output logic              UART_TXD,
    output logic              uart_tx_busy
);

    localparam logic [UART_BAUD_W-1:0]    PRE_LAST = UART_BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = UART_BIT_CNT_W'(DATA_W - 1);

    uart_state_e               state, state_d;
    logic [DATA_W-1:0]         shreg, shreg_d;
    logic [UART_BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [UART_BAUD_W-1:0]    count;
    logic                      bit_tick;
    logic                      clear;
    logic                      txd_d;
    logic                      complete_d;
`ifdef UART_TX_PARITY_EN
    logic                      parity, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) baud_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .count    (count),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        clear      = 1'b0;
        complete_d = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity;
`endif
        case (state)
            UART_IDLE: begin
                clear = 1'b1;
                if (uart_tx_valid) begin
                    shreg_d = uart_tx_data;
                    state_d = UART_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^uart_tx_data;
`endif
                end
            end
            UART_START: begin
                if (bit_tick) begin
                    state_d   = UART_DATA;
                    bit_cnt_d = '0;
                end
            end
            UART_DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_PARITY;
`else
                        state_d = UART_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (bit_tick) begin
                    state_d = UART_STOP;
                end
            end
`endif
            UART_STOP: begin
                // registered pulse lands on the last stop-bit clock
                complete_d = (count == PRE_LAST);
                if (bit_tick) begin
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase

        case (state_d)
            UART_START:  txd_d = 1'b0;
            UART_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            UART_PARITY: txd_d = parity;
`endif
            default:     txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= UART_IDLE;
            bit_cnt          <= '0;
            UART_TXD         <= 1'b1;
            uart_tx_complete <= 1'b0;
            uart_tx_busy     <= 1'b0;
        end else begin
            state            <= state_d;
            bit_cnt          <= bit_cnt_d;
            UART_TXD         <= txd_d;
            uart_tx_complete <= complete_d;
            uart_tx_busy     <= (state_d != UART_IDLE);
        end
    end

    // Data path registers carry no reset; they are always loaded before use.
    always_ff @(posedge clock) begin
        shreg <= shreg_d;
`ifdef UART_TX_PARITY_EN
        parity <= parity_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=4) with a frame-level reference model and fifo model.
module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_tx_valid = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       uart_tx_complete;
    logic       UART_TXD;
    logic       uart_tx_busy;

    int tests = 0;
    int fails = 0;
    int total_complete = 0;

    logic [7:0] q[$];
    bit         ov_en = 1'b0;
    bit         ov_valid = 1'b0;
    logic [7:0] ov_data = 8'h00;

    bit          m_active = 1'b0;
    int          m_pos = 0;
    logic [10:0] m_frame = '1;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clock            (clock),
        .reset            (reset),
        .uart_tx_valid    (uart_tx_valid),
        .uart_tx_data     (uart_tx_data),
        .uart_tx_complete (uart_tx_complete),
        .UART_TXD         (UART_TXD),
        .uart_tx_busy     (uart_tx_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] build_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    // Show-ahead fifo: pops while complete is high, or a directly driven override.
    always @(negedge clock) begin
        #1;
        if (uart_tx_complete && q.size() > 0) void'(q.pop_front());
        if (ov_en) begin
            uart_tx_valid = ov_valid;
            uart_tx_data  = ov_data;
        end else begin
            uart_tx_valid = (q.size() > 0);
            uart_tx_data  = (q.size() > 0) ? q[0] : 8'h00;
        end
    end

    // Reference: a frame is a bit vector, pos counts clocks since the sampling edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_pos == FRAME_CYC - 1) m_active = 1'b0;
            else m_pos++;
        end else if (uart_tx_valid) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_frame  = build_frame(uart_tx_data);
        end
    end

    always @(negedge clock) begin
        logic exp_txd, exp_busy, exp_cmp;
        exp_txd  = m_active ? m_frame[m_pos / C] : 1'b1;
        exp_busy = m_active;
        exp_cmp  = m_active && (m_pos == FRAME_CYC - 1);
        tests++;
        if ({UART_TXD, uart_tx_busy, uart_tx_complete} !== {exp_txd, exp_busy, exp_cmp}) begin
            fails++;
            $display("FAIL model_cycle t=%0t txd/busy/complete got %b%b%b want %b%b%b",
                     $time, UART_TXD, uart_tx_busy, uart_tx_complete, exp_txd, exp_busy, exp_cmp);
        end
        if (uart_tx_complete === 1'b1) total_complete++;
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (uart_tx_busy !== 1'b1 && n < 200);
    endtask

    // Captures one frame mid-bit starting at its first busy cycle.
    task automatic run_frame(input logic [10:0] exp_line, input int exp_wait, input string name);
        int n, cc, nc, nb;
        logic [10:0] rec;
        wait_busy(n);
        if (uart_tx_busy !== 1'b1) begin
            chk({name, "_start_timeout"}, n, -1);
            return;
        end
        if (exp_wait > 0) chk({name, "_idle_gap"}, n, exp_wait);
        rec = '1;
        cc  = -1;
        nc  = 0;
        nb  = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k > 0) @(negedge clock);
            if (k % C == 1) rec[k / C] = UART_TXD;
            if (uart_tx_busy === 1'b1) nb++;
            if (uart_tx_complete === 1'b1) begin
                nc++;
                cc = k + 1;
            end
        end
        chk({name, "_line"}, int'(rec), int'(exp_line));
        chk({name, "_complete_cycle"}, cc, FRAME_CYC);
        chk({name, "_complete_count"}, nc, 1);
        chk({name, "_busy_cycles"}, nb, FRAME_CYC);
    endtask

    initial begin
        int bad, n;
        repeat (3) @(negedge clock);
        chk("reset_txd", int'(UART_TXD), 1);
        chk("reset_busy", int'(uart_tx_busy), 0);
        chk("reset_complete", int'(uart_tx_complete), 0);
        reset = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (UART_TXD !== 1'b1 || uart_tx_busy !== 1'b0 || uart_tx_complete !== 1'b0) bad++;
        end
        chk("idle_100", bad, 0);

`ifndef UART_TX_PARITY_EN
        q.push_back(8'h55);
        run_frame(11'b11010101010, -1, "b55");
        repeat (5) @(negedge clock);

        q.push_back(8'hA5);
        q.push_back(8'h3C);
        run_frame(11'b11101001010, -1, "bA5");
        run_frame(11'b11001111000, 2, "b3C");
        repeat (5) @(negedge clock);

        ov_en    = 1'b1;
        ov_valid = 1'b1;
        ov_data  = 8'hFF;
        fork
            run_frame(11'b11111111110, -1, "bFF_hold");
            begin
                repeat (11) @(negedge clock);
                ov_valid = 1'b0;
                ov_data  = 8'h00;
            end
        join
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (uart_tx_busy !== 1'b0) bad++;
        end
        chk("idle_after_ff", bad, 0);
        ov_en = 1'b0;

        q.push_back(8'h00);
        wait_busy(n);
        repeat (14) @(negedge clock);
        chk("pre_reset_txd", int'(UART_TXD), 0);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_txd", int'(UART_TXD), 1);
        chk("async_reset_busy", int'(uart_tx_busy), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_frame(11'b11000000000, -1, "b00_fresh");
        repeat (5) @(negedge clock);
        chk("total_complete", total_complete, 5);
`else
        q.push_back(8'h07);
        run_frame(11'b11000001110, -1, "p07");
        repeat (5) @(negedge clock);
        q.push_back(8'h03);
        run_frame(11'b10000000110, -1, "p03");
        repeat (5) @(negedge clock);
        chk("total_complete", total_complete, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
